// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 hex matrix keypad (Pmod KYPD style). One row is driven low at
//   a time. The synchronized column lines are sampled at the end of each row
//   period. At the end of every full sweep the sweep is classified as NONE,
//   SINGLE(key) or MULTI, and a debounce FSM turns that classification into
//   exactly one validated key event per press. Each accepted key code shifts
//   into value_out, which a seven-segment display driver consumes directly.
//
// Ports
//   clk_in         in   1      system clock
//   rst_low_in     in   1      asynchronous, active-low reset
//   col_in         in   4      column lines, active-low, asynchronous to clk_in
//   clear_in       in   1      synchronous clear of value_out
//   row_out        out  4      row drives, active-low, one-hot-low
//   key_code_out   out  4      hex code of the last accepted key
//   key_valid_out  out  1      one-cycle pulse when a key is accepted
//   key_held_out   out  1      high until the accepted key has debounced its release
//   value_out      out  WIDTH  accepted key codes, newest nibble in [3:0]

module keypad_scanner #(
    parameter int CLK_PERIOD     = 10,
    parameter int SCAN_RATE      = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int WIDTH          = 32
) (
    input  logic             clk_in,
    input  logic             rst_low_in,
    input  logic [3:0]       col_in,
    input  logic             clear_in,
    output logic [3:0]       row_out,
    output logic [3:0]       key_code_out,
    output logic             key_valid_out,
    output logic             key_held_out,
    output logic [WIDTH-1:0] value_out
);

    localparam int ROW_CLKS = (1000000000 / SCAN_RATE) / 4 / CLK_PERIOD;
    localparam int CNT_W    = $clog2(ROW_CLKS);
    localparam int DB_W     = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_CLKS - 1);
    localparam logic [DB_W-1:0]  DB_PRE   = DB_W'(DEBOUNCE_SCANS - 1);
    localparam logic [DB_W-1:0]  DB_FULL  = DB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    // Hex legend of the keypad, col0 is the leftmost column.
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    function automatic logic [2:0] count_low(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [1:0] first_low(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    // Synchronizer, scan counters and sweep accumulator
    logic [3:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [1:0]       row_idx_q;
    logic [3:0]       row_q;
    logic [1:0]       hits_q;      // low columns seen so far this sweep, saturates at 2
    logic [3:0]       hit_key_q;   // key of the single hit, if there was one

    logic             row_last, sweep_end;
    logic [3:0]       lows;
    logic [2:0]       row_hits, hit_sum;
    logic [1:0]       hits_total;
    logic [3:0]       row_key, key_total;
    logic             sweep_none, sweep_single;

    always_comb begin
        row_last   = (clk_cnt_q == ROW_LAST);
        sweep_end  = row_last && (row_idx_q == 2'd3);
        lows       = ~sync2_q;
        row_hits   = count_low(lows);
        row_key    = keymap(row_idx_q, first_low(lows));
        hit_sum    = {1'b0, hits_q} + row_hits;
        hits_total = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        // When the total is exactly one, the hit came either from this row
        // or from an earlier one; pick whichever source saw it.
        key_total  = (row_hits == 3'd1) ? row_key : hit_key_q;
        sweep_none   = sweep_end && (hits_total == 2'd0);
        sweep_single = sweep_end && (hits_total == 2'd1);
    end

    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            clk_cnt_q <= '0;
            row_idx_q <= 2'd0;
            row_q     <= 4'b1110;
            hits_q    <= 2'd0;
            hit_key_q <= 4'h0;
        end else begin
            sync1_q <= col_in;
            sync2_q <= sync1_q;
            if (row_last) begin
                clk_cnt_q <= '0;
                row_idx_q <= row_idx_q + 2'd1;
                row_q     <= {row_q[2:0], row_q[3]};
                hits_q    <= sweep_end ? 2'd0 : hits_total;
                hit_key_q <= sweep_end ? 4'h0 : key_total;
            end else begin
                clk_cnt_q <= clk_cnt_q + CNT_W'(1);
            end
        end
    end

    assign row_out = row_q;

    // Debounce FSM: state register
    state_t          state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            accept;

    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            state_q  <= IDLE;
            cand_q   <= 4'h0;
            db_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Debounce FSM: next state, only moves at sweep end
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        accept   = 1'b0;
        if (sweep_end) begin
            case (state_q)
                IDLE: begin
                    if (sweep_single) begin
                        state_d  = PRESS_DB;
                        cand_d   = key_total;
                        db_cnt_d = DB_W'(1);
                    end
                end
                PRESS_DB: begin
                    if (sweep_single && (key_total == cand_q)) begin
                        if (db_cnt_q == DB_PRE) begin
                            accept   = 1'b1;
                            state_d  = HELD;
                            db_cnt_d = DB_FULL;
                        end else begin
                            db_cnt_d = db_cnt_q + DB_W'(1);
                        end
                    end else if (sweep_single) begin
                        cand_d   = key_total;
                        db_cnt_d = DB_W'(1);
                    end else begin
                        state_d  = IDLE;
                        db_cnt_d = '0;
                    end
                end
                HELD: begin
                    if (sweep_none) begin
                        state_d  = RELEASE_DB;
                        db_cnt_d = DB_W'(1);
                    end
                end
                default: begin
                    if (sweep_none) begin
                        if (db_cnt_q == DB_PRE) begin
                            state_d  = IDLE;
                            db_cnt_d = '0;
                        end else begin
                            db_cnt_d = db_cnt_q + DB_W'(1);
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
            endcase
        end
    end

    // Debounce FSM: outputs
    always_comb begin
        key_held_out = (state_q == HELD) || (state_q == RELEASE_DB);
    end

    // Accept actions, registered
    logic             valid_q;
    logic [3:0]       code_q, code_d;
    logic [WIDTH-1:0] value_q, value_d, value_base;

    always_comb begin
        code_d     = accept ? cand_q : code_q;
        // A clear coinciding with an accept keeps only the new nibble.
        value_base = clear_in ? '0 : value_q;
        value_d    = accept ? ((value_base << 4) | WIDTH'(cand_q)) : value_base;
    end

    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            valid_q <= 1'b0;
            code_q  <= 4'h0;
            value_q <= '0;
        end else begin
            valid_q <= accept;
            code_q  <= code_d;
            value_q <= value_d;
        end
    end

    assign key_valid_out = valid_q;
    assign key_code_out  = code_q;
    assign value_out     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with ROW_CLKS=10 (40-cycle sweeps),
//   DEBOUNCE_SCANS=3 and WIDTH=16. A keypad model pulls column c low while
//   row r is driven low for every pressed key (bit r*4+c of "pressed").
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col;
    logic        clear;
    logic [3:0]  row;
    logic [3:0]  code;
    logic        valid;
    logic        held;
    logic [15:0] value;

    logic [15:0] pressed;
    int          errors = 0;
    int          checks = 0;
    int          ncyc   = 0;
    int          pulses = 0;
    int          p0;

    keypad_scanner #(
        .CLK_PERIOD    (10),
        .SCAN_RATE     (2500000),
        .DEBOUNCE_SCANS(3),
        .WIDTH         (16)
    ) dut (
        .clk_in       (clk),
        .rst_low_in   (rst_n),
        .col_in       (col),
        .clear_in     (clear),
        .row_out      (row),
        .key_code_out (code),
        .key_valid_out(valid),
        .key_held_out (held),
        .value_out    (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && (row[r] == 1'b0)) col[c] = 1'b0;
    end

    always @(posedge clk) if (valid === 1'b1) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        ncyc += n;
    endtask

    // Move to the start of a sweep (row 0, count 0).
    task automatic align();
        while (ncyc % 40 != 0) step(1);
    endtask

    task automatic press_release(input int idx, input int hold_sw, input int rel_sw);
        align();
        pressed = 16'h0;
        pressed[idx] = 1'b1;
        step(40 * hold_sw);
        pressed = 16'h0;
        step(40 * rel_sw);
    endtask

    initial begin
        rst_n   = 1'b0;
        clear   = 1'b0;
        pressed = 16'h0;
        repeat (3) @(negedge clk);

        // 1. reset values and row stepping
        check("rst_row",   32'(row),   32'hE);
        check("rst_code",  32'(code),  32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_held",  32'(held),  32'h0);
        check("rst_value", 32'(value), 32'h0);
        rst_n = 1'b1;
        ncyc  = 0;
        step(5);  check("row0", 32'(row), 32'hE);
        step(10); check("row1", 32'(row), 32'hD);
        step(10); check("row2", 32'(row), 32'hB);
        step(10); check("row3", 32'(row), 32'h7);
        step(10); check("row_wrap", 32'(row), 32'hE);

        // 2. key 5 held 10 sweeps, then released
        align();
        p0 = pulses;
        pressed[5] = 1'b1;
        step(119);
        check("k5_pre_valid", 32'(valid), 32'h0);
        check("k5_pre_held",  32'(held),  32'h0);
        step(1);
        check("k5_valid", 32'(valid), 32'h1);
        check("k5_held",  32'(held),  32'h1);
        check("k5_code",  32'(code),  32'h5);
        check("k5_value", 32'(value), 32'h0005);
        step(1);
        check("k5_valid_drop", 32'(valid), 32'h0);
        check("k5_held_on",    32'(held),  32'h1);
        step(279);
        pressed = 16'h0;
        step(119);
        check("k5_rel_held", 32'(held), 32'h1);
        step(1);
        check("k5_rel_done", 32'(held), 32'h0);
        check("k5_pulses", 32'(pulses - p0), 32'd1);

        // 3. keys 1, 2, 3, A, then 7
        p0 = pulses;
        press_release(0, 4, 4);
        press_release(1, 4, 4);
        press_release(2, 4, 4);
        press_release(3, 4, 4);
        check("seq_value4", 32'(value), 32'h123A);
        press_release(8, 4, 4);
        check("seq_value5", 32'(value), 32'h23A7);
        check("seq_code",   32'(code),  32'h7);
        check("seq_pulses", 32'(pulses - p0), 32'd5);

        // 4. press bounce, then release bounce while held
        p0 = pulses;
        repeat (5) press_release(8, 2, 1);
        check("bnc_value",  32'(value), 32'h23A7);
        check("bnc_pulses", 32'(pulses - p0), 32'd0);
        check("bnc_held",   32'(held),  32'h0);
        align();
        pressed[8] = 1'b1;
        step(160);
        pressed = 16'h0;
        step(40);
        check("rbnc_held1", 32'(held), 32'h1);
        pressed[8] = 1'b1;
        step(80);
        check("rbnc_held2", 32'(held), 32'h1);
        pressed = 16'h0;
        step(160);
        check("rbnc_released", 32'(held), 32'h0);
        check("rbnc_pulses", 32'(pulses - p0), 32'd1);
        check("rbnc_value",  32'(value), 32'h3A77);

        // 5. keys 1 and 2 together, then 2 alone
        align();
        p0 = pulses;
        pressed = 16'h0003;
        step(240);
        check("multi_held",   32'(held), 32'h0);
        check("multi_pulses", 32'(pulses - p0), 32'd0);
        check("multi_value",  32'(value), 32'h3A77);
        pressed = 16'h0002;
        step(119);
        check("k2_pre_valid", 32'(valid), 32'h0);
        step(1);
        check("k2_valid", 32'(valid), 32'h1);
        check("k2_code",  32'(code),  32'h2);
        check("k2_value", 32'(value), 32'hA772);
        pressed = 16'h0;
        step(160);
        check("k2_pulses", 32'(pulses - p0), 32'd1);

        // 6. clear, clear coinciding with accept, reset mid-debounce
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clr_value", 32'(value), 32'h0);
        check("clr_code",  32'(code),  32'h2);
        press_release(0, 4, 4);
        press_release(1, 4, 4);
        press_release(2, 4, 4);
        press_release(4, 4, 4);
        check("pre_c_value", 32'(value), 32'h1234);
        align();
        pressed[11] = 1'b1;
        step(119);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clracc_value", 32'(value), 32'h000C);
        check("clracc_valid", 32'(valid), 32'h1);
        check("clracc_code",  32'(code),  32'hC);
        pressed = 16'h0;
        step(160);

        align();
        pressed[10] = 1'b1;
        step(80);
        check("pdb_held", 32'(held), 32'h0);
        p0 = pulses;
        rst_n   = 1'b0;
        pressed = 16'h0;
        #1;
        check("mrst_row",   32'(row),   32'hE);
        check("mrst_code",  32'(code),  32'h0);
        check("mrst_valid", 32'(valid), 32'h0);
        check("mrst_held",  32'(held),  32'h0);
        check("mrst_value", 32'(value), 32'h0);
        step(3);
        rst_n = 1'b1;
        ncyc  = 0;
        step(200);
        check("mrst_pulses", 32'(pulses - p0), 32'd0);
        check("mrst_value2", 32'(value), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
